// File: rtl/apb_spi_pkg.sv
// Shared definitions for the APB-to-SPI master bridge: register offsets
// (word index PADDR[3:2]), STATUS/CTRL bit positions and FSM encoding.
package apb_spi_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_TXDATA = 2'd2;
  localparam logic [1:0] REG_RXDATA = 2'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int ST_BUSY     = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_RX_VALID = 3;
  localparam int ST_RX_OVR   = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_XFER   = 2'd2
  } state_t;

endpackage

// File: rtl/spi_tx_fifo.sv
// Byte-wide circular TX FIFO; pointers carry one extra wrap bit so that
// full and empty are distinguishable. Push and pop may occur together.
module spi_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [7:0] push_data_bi,
  input  logic       pop_i,
  output logic [7:0] head_bo,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (push_i) r_wptr <= r_wptr + 1'b1;
      if (pop_i)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wptr[AW-1:0]] <= push_data_bi;
  end

  assign head_bo = r_mem[r_rptr[AW-1:0]];
  assign full_o  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign empty_o = (r_wptr == r_rptr);

endmodule

// File: rtl/apb_spi_master_bridge.sv
// APB3 register front-end feeding an SPI master driver through a TX FIFO.
// Optional macro APB_SPI_IRQ_EN adds CTRL.IRQ_EN and a registered irq_o.
module apb_spi_master_bridge
  import apb_spi_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [ADDR_W-1:0] paddr_bi,
  input  logic [31:0]       pwdata_bi,
  output logic [31:0]       prdata_bo,
  output logic              pready_o,
  output logic              pslverr_o,
  output logic              spi_start_o,
  output logic [7:0]        spi_data_bo,
  input  logic              spi_busy_i,
  input  logic [7:0]        spi_data_bi,
`ifdef APB_SPI_IRQ_EN
  output logic              irq_o,
`endif
  output logic [1:0]        dbg_state_o
);

  // Handshakes: APB access completes in the cycle psel_i & penable_i are high
  // (pready_o tied 1). Driver side: spi_start_o stays high with spi_data_bo
  // stable until spi_busy_i is seen high; the fall of spi_busy_i marks the
  // cycle spi_data_bi is valid and captured.
  state_t      r_state;
  logic        r_start;
  logic [7:0]  r_tx_byte;
  logic [7:0]  r_rx_byte;
  logic        r_rx_valid;
  logic        r_rx_ovr;
  logic        r_en;

  logic        w_access, w_wr, w_rd;
  logic [1:0]  w_reg;
  logic        w_push, w_pop, w_full, w_empty, w_capture, w_rx_read, w_ovr_clr;
  logic [7:0]  w_head;
  logic [31:0] w_status, w_ctrl;
  logic        w_unused;

  assign w_access  = psel_i & penable_i;
  assign w_wr      = w_access & pwrite_i;
  assign w_rd      = w_access & ~pwrite_i;
  assign w_reg     = paddr_bi[3:2];
  assign w_push    = w_wr && (w_reg == REG_TXDATA) && !w_full;
  assign w_pop     = (r_state == S_IDLE) && r_en && !w_empty;
  assign w_capture = (r_state == S_XFER) && !spi_busy_i;
  assign w_rx_read = w_rd && (w_reg == REG_RXDATA);
  assign w_ovr_clr = w_wr && (w_reg == REG_STATUS) && pwdata_bi[ST_RX_OVR];
  assign w_unused  = ^{paddr_bi, pwdata_bi[31:8]};

  spi_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (w_push),
    .push_data_bi (pwdata_bi[7:0]),
    .pop_i        (w_pop),
    .head_bo      (w_head),
    .full_o       (w_full),
    .empty_o      (w_empty)
  );

`ifdef APB_SPI_IRQ_EN
  logic r_irq_en;
  logic r_irq;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_en     <= 1'b0;
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr && (w_reg == REG_CTRL)) begin
        r_en     <= pwdata_bi[CTRL_EN];
        r_irq_en <= pwdata_bi[CTRL_IRQ_EN];
      end
      r_irq <= r_irq_en & (r_rx_valid | r_rx_ovr | (w_empty & (r_state == S_IDLE)));
    end
  end

  assign irq_o  = r_irq;
  assign w_ctrl = {30'd0, r_irq_en, r_en};
`else
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_en <= 1'b0;
    else if (w_wr && (w_reg == REG_CTRL)) r_en <= pwdata_bi[CTRL_EN];
  end

  assign w_ctrl = {31'd0, r_en};
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_start    <= 1'b0;
      r_tx_byte  <= 8'd0;
      r_rx_byte  <= 8'd0;
      r_rx_valid <= 1'b0;
      r_rx_ovr   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_pop) begin
          r_tx_byte <= w_head;
          r_start   <= 1'b1;
          r_state   <= S_LAUNCH;
        end
        S_LAUNCH: if (spi_busy_i) begin
          r_start <= 1'b0;
          r_state <= S_XFER;
        end
        S_XFER: if (!spi_busy_i) r_state <= S_IDLE;
        default: begin
          r_start <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
      // A capture beats a same-cycle RXDATA read so the new byte is not lost.
      if (w_capture) begin
        r_rx_byte  <= spi_data_bi;
        r_rx_valid <= 1'b1;
      end else if (w_rx_read) begin
        r_rx_valid <= 1'b0;
      end
      if (w_capture && r_rx_valid) r_rx_ovr <= 1'b1;
      else if (w_ovr_clr)          r_rx_ovr <= 1'b0;
    end
  end

  assign w_status = {27'd0, r_rx_ovr, r_rx_valid, w_empty, w_full, (r_state != S_IDLE)};

  always_comb begin
    prdata_bo = 32'd0;
    if (w_access) begin
      case (w_reg)
        REG_CTRL:   prdata_bo = w_ctrl;
        REG_STATUS: prdata_bo = w_status;
        REG_RXDATA: prdata_bo = {24'd0, r_rx_byte};
        default:    prdata_bo = 32'd0;
      endcase
    end
  end

  assign pready_o    = 1'b1;
  assign pslverr_o   = w_wr && (w_reg == REG_TXDATA) && w_full;
  assign spi_start_o = r_start;
  assign spi_data_bo = r_tx_byte;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_apb_spi_master_bridge.sv
// Bench for apb_spi_master_bridge: table of register accesses, hand-written
// transfer sequences and an SPI slave model checking bytes against exp_q.
module tb_apb_spi_master_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic        spi_start, spi_busy;
  logic [7:0]  spi_dout, spi_din;
  logic [1:0]  dbg_state;
`ifdef APB_SPI_IRQ_EN
  logic        irq;
`endif

  apb_spi_master_bridge #(.FIFO_DEPTH(4), .ADDR_W(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .psel_i      (psel),
    .penable_i   (penable),
    .pwrite_i    (pwrite),
    .paddr_bi    (paddr),
    .pwdata_bi   (pwdata),
    .prdata_bo   (prdata),
    .pready_o    (pready),
    .pslverr_o   (pslverr),
    .spi_start_o (spi_start),
    .spi_data_bo (spi_dout),
    .spi_busy_i  (spi_busy),
    .spi_data_bi (spi_din),
`ifdef APB_SPI_IRQ_EN
    .irq_o       (irq),
`endif
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  int cmp_cnt  = 0;
  int err_cnt  = 0;
  int xfer_cnt = 0;
  int hold_len = 3;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] swap(input logic [7:0] b);
    return {b[3:0], b[7:4]};
  endfunction

  task automatic apb_xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    #3;
    rdata = prdata;
    err   = pslverr;
    check("pready", {31'd0, pready}, 32'd1);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd_chk(input string name, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic e;
    apb_xfer(1'b0, addr, 32'd0, d, e);
    check(name, d, exp);
  endtask

  task automatic apb_wr_chk(input string name, input logic [3:0] addr, input logic [31:0] data,
                            input logic exp_err);
    logic [31:0] d;
    logic e;
    apb_xfer(1'b1, addr, data, d, e);
    check(name, {31'd0, e}, {31'd0, exp_err});
  endtask

  task automatic push_tx(input logic [7:0] b);
    exp_q.push_back(b);
    apb_wr_chk("txdata_wr_err", 4'h8, {24'd0, b}, 1'b0);
  endtask

  task automatic wait_xfers(input int target);
    int t = 0;
    while (xfer_cnt < target && t < 2000) begin
      @(posedge clk);
      t++;
    end
    check("xfer_timeout", {31'd0, xfer_cnt >= target}, 32'd1);
    repeat (3) @(posedge clk);
  endtask

  // SPI slave: answers each byte with its nibble swap after a random delay.
  initial begin : spi_slave
    logic [7:0] b;
    int d;
    spi_busy = 1'b0;
    spi_din  = 8'd0;
    forever begin
      @(posedge clk); #1;
      if (!rst && spi_start && !spi_busy) begin
        b = spi_dout;
        if (exp_q.size() == 0) check("unexpected_start", {24'd0, b}, 32'hFFFF_FFFF);
        else check("tx_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
        d = $urandom_range(0, 2);
        repeat (d) begin
          @(posedge clk); #1;
          check("start_hold", {31'd0, spi_start}, 32'd1);
          check("data_stable", {24'd0, spi_dout}, {24'd0, b});
        end
        spi_busy = 1'b1;
        @(posedge clk); #1;
        check("start_drop", {31'd0, spi_start}, 32'd0);
        for (int i = 0; i < hold_len; i++) begin
          if (rst) break;
          @(posedge clk); #1;
        end
        spi_din  = swap(b);
        spi_busy = 1'b0;
        if (!rst) xfer_cnt++;
      end
    end
  end

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

`ifdef APB_SPI_IRQ_EN
  localparam logic [31:0] CTRL_RB = 32'd3;
`else
  localparam logic [31:0] CTRL_RB = 32'd1;
`endif

  vec_t vecs[11];

  initial begin : main
    logic [31:0] d;
    logic e;
    int t;
    vecs[0]  = '{1'b0, 4'h4, 32'd0,          32'h04,  1'b0};
    vecs[1]  = '{1'b0, 4'h0, 32'd0,          32'h00,  1'b0};
    vecs[2]  = '{1'b0, 4'h8, 32'd0,          32'h00,  1'b0};
    vecs[3]  = '{1'b0, 4'hC, 32'd0,          32'h00,  1'b0};
    vecs[4]  = '{1'b1, 4'h0, 32'd3,          32'h00,  1'b0};
    vecs[5]  = '{1'b0, 4'h0, 32'd0,          CTRL_RB, 1'b0};
    vecs[6]  = '{1'b1, 4'h0, 32'd0,          32'h00,  1'b0};
    vecs[7]  = '{1'b1, 4'hC, 32'hFF,         32'h00,  1'b0};
    vecs[8]  = '{1'b1, 4'h4, 32'hFFFF_FFEF,  32'h00,  1'b0};
    vecs[9]  = '{1'b0, 4'h4, 32'd0,          32'h04,  1'b0};
    vecs[10] = '{1'b0, 4'h0, 32'd0,          32'h00,  1'b0};

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 4'h0; pwdata = 32'd0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_start", {31'd0, spi_start}, 32'd0);
    check("rst_pslverr", {31'd0, pslverr}, 32'd0);
    check("rst_prdata", prdata, 32'd0);
    check("rst_pready", {31'd0, pready}, 32'd1);
    check("rst_state", {30'd0, dbg_state}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, d, e);
      if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rd);
      check($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
    end

    // Single transfer 0x35 -> slave answers 0x53.
    apb_wr_chk("ctrl_en", 4'h0, 32'd1, 1'b0);
    push_tx(8'h35);
    wait_xfers(1);
    apb_rd_chk("status_rxv", 4'h4, 32'h0C);
    apb_rd_chk("rxdata_53", 4'hC, 32'h53);
    apb_rd_chk("status_rxv_clr", 4'h4, 32'h04);

    // Fill FIFO with EN=0, overflow, then drain in order.
    apb_wr_chk("ctrl_dis", 4'h0, 32'd0, 1'b0);
    push_tx(8'h99);
    push_tx(8'h0A);
    push_tx(8'h11);
    push_tx(8'h2C);
    apb_rd_chk("status_full", 4'h4, 32'h02);
    apb_wr_chk("overflow_err", 4'h8, 32'h77, 1'b1);
    apb_rd_chk("status_full2", 4'h4, 32'h02);
    apb_wr_chk("ctrl_en2", 4'h0, 32'd1, 1'b0);
    wait_xfers(5);
    check("exp_q_drained", exp_q.size(), 32'd0);
    apb_rd_chk("status_ovr", 4'h4, 32'h1C);
    apb_rd_chk("rxdata_last", 4'hC, 32'hC2);
    apb_rd_chk("status_ovr_only", 4'h4, 32'h14);
    apb_wr_chk("ovr_clr_wr", 4'h4, 32'h10, 1'b0);
    apb_rd_chk("status_ovr_clr", 4'h4, 32'h04);

    // Asynchronous reset in the middle of a long transfer.
    hold_len = 40;
    push_tx(8'h5A);
    t = 0;
    while (dbg_state != 2'd2 && t < 200) begin
      @(posedge clk);
      t++;
    end
    check("reach_xfer", {30'd0, dbg_state}, 32'd2);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_start", {31'd0, spi_start}, 32'd0);
    check("arst_state", {30'd0, dbg_state}, 32'd0);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 4'h4;
    #1;
    check("arst_status", prdata, 32'h04);
    psel = 1'b0; penable = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    hold_len = 3;
    repeat (10) begin
      @(posedge clk); #1;
      check("no_spurious_start", {31'd0, spi_start}, 32'd0);
    end
    apb_rd_chk("post_rst_status", 4'h4, 32'h04);
    apb_rd_chk("post_rst_ctrl", 4'h0, 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
